rs_wakeup_select: RTL and testbench

Parametrised reservation station for the out-of-order core: accepts renamed instructions from the decoder, tracks up to two source operands per entry, captures results from any number of CDB broadcast ports, and issues one ready entry per cycle to the ALU under a valid/ready handshake. It sits between the decoder/ROB rename stage and the ALU, and succeeds the fixed four-entry, two-bus station with configurable depth, configurable CDB port count, ALU backpressure, an occupancy output and optional oldest-first selection.

---
 rtl/rs_pkg.sv | 29 ++
 rtl/rs_pick.sv | 41 ++++
 rtl/rs_wakeup_select.sv | 244 ++++++++++++++++++++++++
 tb/tb_rs_wakeup_select.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared constants and entry types for the reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int XLEN             = 32;
    localparam int TYPE_BIT_DEFAULT = 5;

    typedef struct packed {
        logic [XLEN-1:0] val;
        logic            has_dep;
    } rs_opnd_t;

    // Tag, type and ROB id widths are module parameters, so they live beside this struct.
    typedef struct packed {
        logic     busy;
        rs_opnd_t r1;
        rs_opnd_t r2;
    } rs_entry_t;

    function automatic logic entry_ready(input rs_entry_t e);
        return e.busy && !e.r1.has_dep && !e.r2.has_dep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pick
//  Description : Picks one requester: lowest index, or oldest via age matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_pick
    import rs_pkg::*;
#(
    parameter int N       = 8,
    parameter bit USE_AGE = 1'b0
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0][N-1:0]  age_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    // age_i[i][j] set means entry j was allocated before entry i.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        if (USE_AGE) begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i] && ((age_i[i] & req_i) == '0)) begin
                    idx_o = IW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    idx_o = IW'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_wakeup_select.sv
`default_nettype none
// ============================================================================
//  Module      : rs_wakeup_select
//  Description : Reservation station with CDB wakeup and single ALU issue.
//                Define RS_AGE_ORDER_EN for oldest-first issue selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_wakeup_select
    import rs_pkg::*;
#(
    parameter int RS_SIZE      = 8,
    parameter int ROB_SIZE_BIT = 4,
    parameter int TYPE_BIT     = TYPE_BIT_DEFAULT,
    parameter int CDB_PORTS    = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               rdy_in,
    input  logic                               rob_clear,
    input  logic                               in_valid,
    input  logic [TYPE_BIT-1:0]                in_type,
    input  logic [XLEN-1:0]                    in_r1_val,
    input  logic [XLEN-1:0]                    in_r2_val,
    input  logic                               in_r1_has_dep,
    input  logic                               in_r2_has_dep,
    input  logic [ROB_SIZE_BIT-1:0]            in_r1_dep,
    input  logic [ROB_SIZE_BIT-1:0]            in_r2_dep,
    input  logic [ROB_SIZE_BIT-1:0]            in_rob_id,
    output logic                               rs_full,
    output logic [$clog2(RS_SIZE):0]           rs_count,
    input  logic [CDB_PORTS-1:0]               cdb_valid,
    input  logic [CDB_PORTS*ROB_SIZE_BIT-1:0]  cdb_rob_id,
    input  logic [CDB_PORTS*XLEN-1:0]          cdb_value,
    output logic                               alu_valid,
    input  logic                               alu_ready,
    output logic [TYPE_BIT-1:0]                alu_type,
    output logic [XLEN-1:0]                    alu_r1_val,
    output logic [XLEN-1:0]                    alu_r2_val,
    output logic [ROB_SIZE_BIT-1:0]            alu_rob_id
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam int RB    = ROB_SIZE_BIT;

    rs_entry_t           ent_q  [RS_SIZE];
    rs_entry_t           ent_d  [RS_SIZE];
    logic [RB-1:0]       dep1_q [RS_SIZE];
    logic [RB-1:0]       dep1_d [RS_SIZE];
    logic [RB-1:0]       dep2_q [RS_SIZE];
    logic [RB-1:0]       dep2_d [RS_SIZE];
    logic [RB-1:0]       rob_q  [RS_SIZE];
    logic [RB-1:0]       rob_d  [RS_SIZE];
    logic [TYPE_BIT-1:0] type_q [RS_SIZE];
    logic [TYPE_BIT-1:0] type_d [RS_SIZE];

    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic [RS_SIZE-1:0]              ready, free;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age;
    logic [IDX_W-1:0]                pick_idx, free_idx, sel_idx;
    logic                            pick_any, free_any;
    logic                            disp, xfer;
    rs_opnd_t                        in1_op, in2_op;

    // Lowest port index wins when several ports carry the same tag.
    function automatic logic [XLEN:0] cdb_lookup(input logic [RB-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_rob_id[p*RB +: RB] == tag)) begin
                res = {1'b1, cdb_value[p*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    function automatic rs_opnd_t capture(input rs_opnd_t op, input logic [RB-1:0] tag);
        rs_opnd_t      res;
        logic [XLEN:0] hit;
        hit = cdb_lookup(tag);
        res = op;
        if (op.has_dep && hit[XLEN]) begin
            res.val     = hit[XLEN-1:0];
            res.has_dep = 1'b0;
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = entry_ready(ent_q[i]);
            free[i]  = !ent_q[i].busy;
        end
    end

`ifdef RS_AGE_ORDER_EN
    localparam bit AGE_EN = 1'b1;

    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;

    // A new entry is younger than everything still busy after this edge.
    always_comb begin
        age_d = age_q;
        if (disp) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                age_d[i][free_idx] = 1'b0;
            end
            age_d[free_idx] = ~free;
            if (xfer) begin
                age_d[free_idx][sel_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age = age_q;
`else
    localparam bit AGE_EN = 1'b0;

    assign age = '0;
`endif

    rs_pick #(
        .N       (RS_SIZE),
        .USE_AGE (AGE_EN)
    ) u_issue_pick (
        .req_i (ready),
        .age_i (age),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    rs_pick #(
        .N       (RS_SIZE),
        .USE_AGE (1'b0)
    ) u_free_pick (
        .req_i (free),
        .age_i ('0),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    // A stalled offer stays locked so late wakeups cannot steal the slot.
    assign sel_idx   = lock_q ? lock_idx_q : pick_idx;
    assign alu_valid = pick_any;
    assign xfer      = pick_any && alu_ready && rdy_in;
    assign disp      = rdy_in && in_valid && !rob_clear && free_any;
    assign rs_full   = (count_q == CNT_W'(RS_SIZE));
    assign rs_count  = count_q;

    always_comb begin
        alu_type   = '0;
        alu_r1_val = '0;
        alu_r2_val = '0;
        alu_rob_id = '0;
        if (pick_any) begin
            alu_type   = type_q[sel_idx];
            alu_r1_val = ent_q[sel_idx].r1.val;
            alu_r2_val = ent_q[sel_idx].r2.val;
            alu_rob_id = rob_q[sel_idx];
        end
    end

    always_comb begin
        ent_d      = ent_q;
        dep1_d     = dep1_q;
        dep2_d     = dep2_q;
        rob_d      = rob_q;
        type_d     = type_q;
        count_d    = count_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        in1_op.val     = in_r1_val;
        in1_op.has_dep = in_r1_has_dep;
        in2_op.val     = in_r2_val;
        in2_op.has_dep = in_r2_has_dep;
        if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    ent_d[i].r1 = capture(ent_q[i].r1, dep1_q[i]);
                    ent_d[i].r2 = capture(ent_q[i].r2, dep2_q[i]);
                end
            end
            if (xfer) begin
                ent_d[sel_idx].busy = 1'b0;
            end
            if (disp) begin
                ent_d[free_idx].busy = 1'b1;
                ent_d[free_idx].r1   = capture(in1_op, in_r1_dep);
                ent_d[free_idx].r2   = capture(in2_op, in_r2_dep);
                dep1_d[free_idx]     = in_r1_dep;
                dep2_d[free_idx]     = in_r2_dep;
                rob_d[free_idx]      = in_rob_id;
                type_d[free_idx]     = in_type;
            end
            count_d    = count_q + CNT_W'(disp) - CNT_W'(xfer);
            lock_d     = pick_any && !alu_ready;
            lock_idx_d = sel_idx;
            if (rob_clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_d[i].busy = 1'b0;
                end
                count_d = '0;
                lock_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i]  <= '0;
                dep1_q[i] <= '0;
                dep2_q[i] <= '0;
                rob_q[i]  <= '0;
                type_q[i] <= '0;
            end
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ent_q      <= ent_d;
            dep1_q     <= dep1_d;
            dep2_q     <= dep2_d;
            rob_q      <= rob_d;
            type_q     <= type_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_wakeup_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_wakeup_select
//  Description : Scoreboard bench for rs_wakeup_select with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_wakeup_select;

    localparam int RS_SIZE = 8;
    localparam int RB      = 4;
    localparam int TW      = 5;
    localparam int CP      = 2;

    logic          clk = 1'b0;
    logic          rst, rdy, clr, in_valid;
    logic [TW-1:0] in_type;
    logic [31:0]   in_r1_val, in_r2_val;
    logic          in_r1_has_dep, in_r2_has_dep;
    logic [RB-1:0] in_r1_dep, in_r2_dep, in_rob_id;
    logic          rs_full;
    logic [3:0]    rs_count;
    logic [CP-1:0]    cdb_valid;
    logic [CP*RB-1:0] cdb_rob_id;
    logic [CP*32-1:0] cdb_value;
    logic          alu_valid, alu_ready;
    logic [TW-1:0] alu_type;
    logic [31:0]   alu_r1_val, alu_r2_val;
    logic [RB-1:0] alu_rob_id;

    typedef struct {
        logic [TW-1:0] t;
        logic [31:0]   r1;
        logic [31:0]   r2;
        logic [RB-1:0] rob;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rs_wakeup_select #(
        .RS_SIZE      (RS_SIZE),
        .ROB_SIZE_BIT (RB),
        .TYPE_BIT     (TW),
        .CDB_PORTS    (CP)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .rob_clear     (clr),
        .in_valid      (in_valid),
        .in_type       (in_type),
        .in_r1_val     (in_r1_val),
        .in_r2_val     (in_r2_val),
        .in_r1_has_dep (in_r1_has_dep),
        .in_r2_has_dep (in_r2_has_dep),
        .in_r1_dep     (in_r1_dep),
        .in_r2_dep     (in_r2_dep),
        .in_rob_id     (in_rob_id),
        .rs_full       (rs_full),
        .rs_count      (rs_count),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_value     (cdb_value),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_type      (alu_type),
        .alu_r1_val    (alu_r1_val),
        .alu_r2_val    (alu_r2_val),
        .alu_rob_id    (alu_rob_id)
    );

    // Monitor: every accepted issue is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rdy && in_valid && rs_full) begin
            errors++;
            $display("FAIL protocol_full_dispatch: in_valid=1 while rs_full=1, required no dispatch");
        end
        if (!rst && rdy && !clr && alu_valid && alu_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got rob %0d, required no issue", alu_rob_id);
            end else begin
                mon_e = sb.pop_front();
                if (alu_type !== mon_e.t || alu_r1_val !== mon_e.r1 ||
                    alu_r2_val !== mon_e.r2 || alu_rob_id !== mon_e.rob) begin
                    errors++;
                    $display("FAIL issue_rob%0d: got type=%0d r1=0x%0h r2=0x%0h rob=%0d, required type=%0d r1=0x%0h r2=0x%0h rob=%0d",
                             mon_e.rob, alu_type, alu_r1_val, alu_r2_val, alu_rob_id,
                             mon_e.t, mon_e.r1, mon_e.r2, mon_e.rob);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [TW-1:0] t, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [RB-1:0] rob);
        exp_t e;
        e.t = t; e.r1 = r1; e.r2 = r2; e.rob = rob;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [TW-1:0] t,
                            input logic [31:0] v1, input logic h1, input logic [RB-1:0] d1,
                            input logic [31:0] v2, input logic h2, input logic [RB-1:0] d2,
                            input logic [RB-1:0] rob);
        in_valid = 1'b1; in_type = t;
        in_r1_val = v1; in_r1_has_dep = h1; in_r1_dep = d1;
        in_r2_val = v2; in_r2_has_dep = h2; in_r2_dep = d2;
        in_rob_id = rob;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic bcast(input int p, input logic [RB-1:0] tag, input logic [31:0] v);
        cdb_valid[p]            = 1'b1;
        cdb_rob_id[p*RB +: RB]  = tag;
        cdb_value[p*32 +: 32]   = v;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; in_valid = 1'b0; alu_ready = 1'b0;
        in_type = '0; in_r1_val = '0; in_r2_val = '0; in_r1_has_dep = 1'b0;
        in_r2_has_dep = 1'b0; in_r1_dep = '0; in_r2_dep = '0; in_rob_id = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        tick(3);
        check("reset_full",   32'(rs_full),   32'd0);
        check("reset_count",  32'(rs_count),  32'd0);
        check("reset_valid",  32'(alu_valid), 32'd0);
        check("reset_type",   32'(alu_type),  32'd0);
        check("reset_r1",     alu_r1_val,     32'd0);
        check("reset_r2",     alu_r2_val,     32'd0);
        check("reset_rob",    32'(alu_rob_id), 32'd0);
        rst = 1'b0;
        tick(1);

        // Plain ready dispatch issues one cycle later.
        alu_ready = 1'b1;
        push(5'd1, 32'd5, 32'd7, 4'd1);
        dispatch(5'd1, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd1);
        check("count_after_dispatch", 32'(rs_count), 32'd1);
        tick(1);
        check("count_after_issue", 32'(rs_count), 32'd0);

        // Same-cycle bypass from port 1.
        push(5'd2, 32'h55, 32'd9, 4'd2);
        bcast(1, 4'd3, 32'h55);
        dispatch(5'd2, 32'd0, 1'b1, 4'd3, 32'd9, 1'b0, 4'd0, 4'd2);
        cdb_valid = '0;
        tick(1);
        check("count_after_bypass", 32'(rs_count), 32'd0);

        // Wakeup with both ports matching: port 0 wins.
        push(5'd3, 32'h100, 32'hABCD, 4'd3);
        dispatch(5'd3, 32'h100, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd3);
        tick(1);
        check("wait_on_dep", 32'(alu_valid), 32'd0);
        bcast(0, 4'd4, 32'hABCD);
        bcast(1, 4'd4, 32'h1111);
        tick(1);
        cdb_valid = '0;
        tick(1);
        check("count_after_wakeup", 32'(rs_count), 32'd0);

        // Fill all entries, all waiting on tag 6.
        alu_ready = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            push(5'd4, 32'h66, 32'(i), 4'(i));
            dispatch(5'd4, 32'd0, 1'b1, 4'd6, 32'(i), 1'b0, 4'd0, 4'(i));
        end
        check("full_flag", 32'(rs_full), 32'd1);
        check("full_count", 32'(rs_count), 32'd8);
        rdy = 1'b0;
        bcast(0, 4'd6, 32'h99);
        tick(1);
        cdb_valid = '0;
        rdy = 1'b1;
        tick(1);
        check("bcast_lost_when_frozen", 32'(alu_valid), 32'd0);
        check("count_held_when_frozen", 32'(rs_count), 32'd8);
        bcast(0, 4'd6, 32'h66);
        tick(1);
        cdb_valid = '0;
        alu_ready = 1'b1;
        for (int k = 0; k < 20 && rs_count != 0; k++) tick(1);
        check("drain_count", 32'(rs_count), 32'd0);
        check("drain_full", 32'(rs_full), 32'd0);

        // Stall: offer for B must not move to A when A wakes up.
        alu_ready = 1'b0;
        push(5'd6, 32'h20, 32'h21, 4'd9);
        push(5'd5, 32'h22, 32'h10, 4'd8);
        dispatch(5'd5, 32'd0, 1'b1, 4'd2, 32'h10, 1'b0, 4'd0, 4'd8);
        dispatch(5'd6, 32'h20, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 4'd9);
        bcast(0, 4'd2, 32'h22);
        tick(1);
        cdb_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("stall_valid", 32'(alu_valid), 32'd1);
            check("stall_rob", 32'(alu_rob_id), 32'd9);
            tick(1);
        end
        alu_ready = 1'b1;
        tick(3);
        check("count_after_stall", 32'(rs_count), 32'd0);

        // Order: A slot0 issues, B slot1, C reuses slot0; B and C wake together.
        push(5'd7, 32'd1, 32'd2, 4'd10);
`ifdef RS_AGE_ORDER_EN
        push(5'd8, 32'h77, 32'd3, 4'd11);
        push(5'd9, 32'h77, 32'd4, 4'd12);
`else
        push(5'd9, 32'h77, 32'd4, 4'd12);
        push(5'd8, 32'h77, 32'd3, 4'd11);
`endif
        dispatch(5'd7, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd10);
        dispatch(5'd8, 32'd0, 1'b1, 4'd5, 32'd3, 1'b0, 4'd0, 4'd11);
        dispatch(5'd9, 32'd0, 1'b1, 4'd5, 32'd4, 1'b0, 4'd0, 4'd12);
        bcast(0, 4'd5, 32'h77);
        tick(1);
        cdb_valid = '0;
        tick(3);
        check("count_after_order", 32'(rs_count), 32'd0);

        // Flush with concurrent dispatch and pending issue.
        alu_ready = 1'b0;
        dispatch(5'd10, 32'hD, 1'b0, 4'd0, 32'hD, 1'b0, 4'd0, 4'd13);
        check("pre_flush_valid", 32'(alu_valid), 32'd1);
        clr = 1'b1; alu_ready = 1'b1;
        in_valid = 1'b1; in_type = 5'd11; in_r1_val = 32'hE; in_r2_val = 32'hE;
        in_r1_has_dep = 1'b0; in_r2_has_dep = 1'b0; in_rob_id = 4'd14;
        tick(1);
        clr = 1'b0; in_valid = 1'b0; alu_ready = 1'b0;
        check("flush_count", 32'(rs_count), 32'd0);
        check("flush_valid", 32'(alu_valid), 32'd0);
        tick(2);
        check("flush_dropped_valid", 32'(alu_valid), 32'd0);
        check("flush_dropped_count", 32'(rs_count), 32'd0);

        tick(2);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
